// File: rtl/gpr_pkg.sv
// gpr_pkg: shared defaults and types for the general-purpose register file.
//   GPR_DATA_W   default register width
//   GPR_NUM_REGS default register count
//   gpr_state_t  clear-engine state encoding
package gpr_pkg;

    localparam int GPR_DATA_W   = 10;
    localparam int GPR_NUM_REGS = 10;

    typedef enum logic {
        GPR_IDLE,
        GPR_CLEAR
    } gpr_state_t;

endpackage

// File: rtl/gpr_file_if.sv
// gpr_file_if: request/response bundle of the register file.
//   wr_en/wr_addr/wr_data            write port
//   rd0_en/rd0_addr -> rd0_data/rd0_valid   read port 0 (ALU operand A)
//   rd1_en/rd1_addr -> rd1_data/rd1_valid   read port 1 (ALU operand B)
//   clr_req -> busy                  clear-all sweep
//   addr_err                         sticky out-of-range access flag
// Modports: master (datapath side), slave (register file side).
interface gpr_file_if #(
    parameter int DATA_W = 10,
    parameter int ADDR_W = 4
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              rd0_en;
    logic [ADDR_W-1:0] rd0_addr;
    logic [DATA_W-1:0] rd0_data;
    logic              rd0_valid;
    logic              rd1_en;
    logic [ADDR_W-1:0] rd1_addr;
    logic [DATA_W-1:0] rd1_data;
    logic              rd1_valid;
    logic              clr_req;
    logic              busy;
    logic              addr_err;

    modport master (
        output wr_en, wr_addr, wr_data,
        output rd0_en, rd0_addr, rd1_en, rd1_addr,
        output clr_req,
        input  rd0_data, rd0_valid, rd1_data, rd1_valid,
        input  busy, addr_err
    );

    modport slave (
        input  wr_en, wr_addr, wr_data,
        input  rd0_en, rd0_addr, rd1_en, rd1_addr,
        input  clr_req,
        output rd0_data, rd0_valid, rd1_data, rd1_valid,
        output busy, addr_err
    );
endinterface

// File: rtl/gpr_read_port.sv
// gpr_read_port: one registered read port of gpr_file.
//   en/addr        read request (ignored while busy)
//   regs           flattened register array
//   wr_acc/wr_addr/wr_data  accepted write this cycle (forwarding source)
//   data/valid     registered read data and 1-cycle valid pulse
//   oor            accepted request with address >= NUM_REGS (combinational)
// Optional feature: GPR_BYPASS_EN enables write-to-read forwarding.
module gpr_read_port
    import gpr_pkg::*;
#(
    parameter int DATA_W   = GPR_DATA_W,
    parameter int NUM_REGS = GPR_NUM_REGS,
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             busy,
    input  logic                             en,
    input  logic [ADDR_W-1:0]                addr,
    input  logic [NUM_REGS-1:0][DATA_W-1:0]  regs,
    input  logic                             wr_acc,
    input  logic [ADDR_W-1:0]                wr_addr,
    input  logic [DATA_W-1:0]                wr_data,
    output logic [DATA_W-1:0]                data,
    output logic                             valid,
    output logic                             oor
);

`ifdef GPR_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic              accept;
    logic              in_range;
    logic              fwd_hit;
    logic [DATA_W-1:0] mem_val;
    logic [DATA_W-1:0] sel_val;

    assign accept   = en && !busy;
    assign in_range = int'(addr) < NUM_REGS;
    assign oor      = accept && !in_range;
    assign fwd_hit  = BYPASS && wr_acc && (wr_addr == addr);

    // Decoded select keeps out-of-range addresses from indexing the array.
    always_comb begin
        mem_val = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (addr == ADDR_W'(i)) begin
                mem_val = regs[i];
            end
        end
    end

    always_comb begin
        sel_val = '0;
        if (in_range) begin
            sel_val = fwd_hit ? wr_data : mem_val;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data  <= '0;
            valid <= 1'b0;
        end else begin
            valid <= accept;
            if (accept) begin
                data <= sel_val;
            end
        end
    end

endmodule

// File: rtl/gpr_file.sv
// gpr_file: NUM_REGS x DATA_W register file, one write port, two registered
// read ports and a sequenced clear-all engine.
//   clk    clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    gpr_file_if.slave: write, two reads, clr_req/busy, addr_err
// Optional feature: GPR_BYPASS_EN (write-to-read forwarding in the read ports).
module gpr_file
    import gpr_pkg::*;
#(
    parameter  int DATA_W   = GPR_DATA_W,
    parameter  int NUM_REGS = GPR_NUM_REGS,
    localparam int ADDR_W   = $clog2(NUM_REGS)
) (
    input logic       clk,
    input logic       rst_n,
    gpr_file_if.slave bus
);

    logic [NUM_REGS-1:0][DATA_W-1:0] regs_q;

    gpr_state_t        state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              clr_we;
    logic              clr_done;

    logic              busy;
    logic              wr_in_range;
    logic              wr_acc;
    logic              rd0_oor;
    logic              rd1_oor;
    logic              err_set;
    logic              addr_err_q;

    assign busy        = (state_q == GPR_CLEAR);
    assign wr_in_range = int'(bus.wr_addr) < NUM_REGS;
    assign wr_acc      = bus.wr_en && !busy && wr_in_range;
    assign err_set     = (bus.wr_en && !busy && !wr_in_range) || rd0_oor || rd1_oor;

    assign bus.busy     = busy;
    assign bus.addr_err = addr_err_q;

    // Clear engine
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= GPR_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        clr_we   = 1'b0;
        clr_done = 1'b0;
        unique case (state_q)
            GPR_IDLE: begin
                if (bus.clr_req) begin
                    state_d = GPR_CLEAR;
                    idx_d   = '0;
                end
            end
            GPR_CLEAR: begin
                clr_we = 1'b1;
                if (idx_q == ADDR_W'(NUM_REGS - 1)) begin
                    state_d  = GPR_IDLE;
                    idx_d    = '0;
                    clr_done = 1'b1;
                end else begin
                    idx_d = idx_q + ADDR_W'(1);
                end
            end
            default: begin
                state_d = GPR_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // Storage: sweep and host writes are mutually exclusive because wr_acc
    // already excludes busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                if (clr_we && idx_q == ADDR_W'(i)) begin
                    regs_q[i] <= '0;
                end else if (wr_acc && bus.wr_addr == ADDR_W'(i)) begin
                    regs_q[i] <= bus.wr_data;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_err_q <= 1'b0;
        end else if (clr_done) begin
            addr_err_q <= 1'b0;
        end else if (err_set) begin
            addr_err_q <= 1'b1;
        end
    end

    gpr_read_port #(
        .DATA_W  (DATA_W),
        .NUM_REGS(NUM_REGS),
        .ADDR_W  (ADDR_W)
    ) u_rd0 (
        .clk    (clk),
        .rst_n  (rst_n),
        .busy   (busy),
        .en     (bus.rd0_en),
        .addr   (bus.rd0_addr),
        .regs   (regs_q),
        .wr_acc (wr_acc),
        .wr_addr(bus.wr_addr),
        .wr_data(bus.wr_data),
        .data   (bus.rd0_data),
        .valid  (bus.rd0_valid),
        .oor    (rd0_oor)
    );

    gpr_read_port #(
        .DATA_W  (DATA_W),
        .NUM_REGS(NUM_REGS),
        .ADDR_W  (ADDR_W)
    ) u_rd1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .busy   (busy),
        .en     (bus.rd1_en),
        .addr   (bus.rd1_addr),
        .regs   (regs_q),
        .wr_acc (wr_acc),
        .wr_addr(bus.wr_addr),
        .wr_data(bus.wr_data),
        .data   (bus.rd1_data),
        .valid  (bus.rd1_valid),
        .oor    (rd1_oor)
    );

endmodule

// File: tb/tb_gpr_file.sv
// tb_gpr_file: directed bench for gpr_file (DATA_W=10, NUM_REGS=10).
module tb_gpr_file;

    logic clk = 1'b0;
    logic rst_n;

    int n_vec = 0;
    int n_err = 0;

    logic [9:0] exp_regs [10];

    gpr_file_if #(.DATA_W(10), .ADDR_W(4)) intf ();

    gpr_file #(
        .DATA_W  (10),
        .NUM_REGS(10)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (intf)
    );

    always #5 clk = ~clk;

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [9:0] d);
        intf.wr_en   = 1'b1;
        intf.wr_addr = a;
        intf.wr_data = d;
        tick();
        intf.wr_en = 1'b0;
    endtask

    task automatic rd(input int port, input logic [3:0] a, input logic [9:0] exp, input string tag);
        if (port == 0) begin
            intf.rd0_en = 1'b1; intf.rd0_addr = a;
        end else begin
            intf.rd1_en = 1'b1; intf.rd1_addr = a;
        end
        tick();
        intf.rd0_en = 1'b0;
        intf.rd1_en = 1'b0;
        if (port == 0) begin
            expect_eq({tag, "_v0"}, 32'(intf.rd0_valid), 32'd1);
            expect_eq({tag, "_d0"}, 32'(intf.rd0_data), 32'(exp));
        end else begin
            expect_eq({tag, "_v1"}, 32'(intf.rd1_valid), 32'd1);
            expect_eq({tag, "_d1"}, 32'(intf.rd1_data), 32'(exp));
        end
    endtask

    task automatic read_all(input string tag);
        for (int i = 0; i < 10; i++) begin
            rd(i % 2, 4'(i), exp_regs[i], $sformatf("%s_r%0d", tag, i));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] exp_byp;
        int n;

        rst_n         = 1'b0;
        intf.wr_en    = 1'b0;
        intf.wr_addr  = '0;
        intf.wr_data  = '0;
        intf.rd0_en   = 1'b0;
        intf.rd0_addr = '0;
        intf.rd1_en   = 1'b0;
        intf.rd1_addr = '0;
        intf.clr_req  = 1'b0;
        for (int i = 0; i < 10; i++) exp_regs[i] = '0;

        repeat (2) @(posedge clk);
        #1;
        expect_eq("rst_busy", 32'(intf.busy), 32'd0);
        expect_eq("rst_err", 32'(intf.addr_err), 32'd0);
        expect_eq("rst_v0", 32'(intf.rd0_valid), 32'd0);
        expect_eq("rst_d1", 32'(intf.rd1_data), 32'd0);
        rst_n = 1'b1;
        tick();

        // Basic write then dual read of the same register
        wr(4'd3, 10'h155);
        exp_regs[3] = 10'h155;
        intf.rd0_en = 1'b1; intf.rd0_addr = 4'd3;
        intf.rd1_en = 1'b1; intf.rd1_addr = 4'd3;
        tick();
        intf.rd0_en = 1'b0; intf.rd1_en = 1'b0;
        expect_eq("dual_v0", 32'(intf.rd0_valid), 32'd1);
        expect_eq("dual_v1", 32'(intf.rd1_valid), 32'd1);
        expect_eq("dual_d0", 32'(intf.rd0_data), 32'h155);
        expect_eq("dual_d1", 32'(intf.rd1_data), 32'h155);
        tick();
        expect_eq("pulse_v0", 32'(intf.rd0_valid), 32'd0);
        expect_eq("pulse_v1", 32'(intf.rd1_valid), 32'd0);
        expect_eq("hold_d0", 32'(intf.rd0_data), 32'h155);
        expect_eq("hold_d1", 32'(intf.rd1_data), 32'h155);

        // Same-cycle write and read of r5
        wr(4'd5, 10'h011);
`ifdef GPR_BYPASS_EN
        exp_byp = 10'h2AA;
`else
        exp_byp = 10'h011;
`endif
        intf.wr_en = 1'b1; intf.wr_addr = 4'd5; intf.wr_data = 10'h2AA;
        intf.rd0_en = 1'b1; intf.rd0_addr = 4'd5;
        tick();
        intf.wr_en = 1'b0; intf.rd0_en = 1'b0;
        exp_regs[5] = 10'h2AA;
        expect_eq("raw_d0", 32'(intf.rd0_data), 32'(exp_byp));
        rd(0, 4'd5, 10'h2AA, "raw_after");

        // Out-of-range write and read
        expect_eq("err_pre", 32'(intf.addr_err), 32'd0);
        wr(4'd12, 10'h3C3);
        expect_eq("err_wr", 32'(intf.addr_err), 32'd1);
        rd(1, 4'd15, 10'h000, "oor_rd");
        read_all("after_oor");
        expect_eq("err_sticky", 32'(intf.addr_err), 32'd1);

        // Fill, then sweep with ignored traffic
        for (int i = 0; i < 10; i++) begin
            wr(4'(i), 10'(10'h040 + 3 * i));
            exp_regs[i] = 10'(10'h040 + 3 * i);
        end
        rd(1, 4'd9, 10'h05B, "fill_r9");
        intf.clr_req = 1'b1;
        tick();
        intf.clr_req = 1'b0;
        for (int k = 0; k < 10; k++) begin
            expect_eq($sformatf("sweep_busy%0d", k), 32'(intf.busy), 32'd1);
            expect_eq($sformatf("sweep_v0_%0d", k), 32'(intf.rd0_valid), 32'd0);
            expect_eq($sformatf("sweep_v1_%0d", k), 32'(intf.rd1_valid), 32'd0);
            intf.wr_en = 1'b1; intf.wr_addr = 4'd0; intf.wr_data = 10'h3FF;
            intf.rd0_en = 1'b1; intf.rd0_addr = 4'd1;
            intf.rd1_en = 1'b1; intf.rd1_addr = 4'd15;
            intf.clr_req = 1'b1;
            tick();
        end
        intf.wr_en = 1'b0; intf.rd0_en = 1'b0; intf.rd1_en = 1'b0; intf.clr_req = 1'b0;
        expect_eq("sweep_end_busy", 32'(intf.busy), 32'd0);
        expect_eq("sweep_end_err", 32'(intf.addr_err), 32'd0);
        expect_eq("sweep_end_v0", 32'(intf.rd0_valid), 32'd0);
        for (int i = 0; i < 10; i++) exp_regs[i] = '0;
        read_all("after_sweep");

        // Reset in the middle of a sweep
        wr(4'd2, 10'h1AB);
        rd(0, 4'd2, 10'h1AB, "pre_rst");
        rd(1, 4'd15, 10'h000, "pre_rst_oor");
        expect_eq("pre_rst_err", 32'(intf.addr_err), 32'd1);
        intf.clr_req = 1'b1;
        tick();
        intf.clr_req = 1'b0;
        repeat (3) tick();
        expect_eq("mid_busy", 32'(intf.busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        expect_eq("async_busy", 32'(intf.busy), 32'd0);
        expect_eq("async_err", 32'(intf.addr_err), 32'd0);
        expect_eq("async_d0", 32'(intf.rd0_data), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        expect_eq("post_rst_busy", 32'(intf.busy), 32'd0);
        rd(0, 4'd2, 10'h000, "post_rst_r2");

        // Write and clr_req in the same idle cycle
        wr(4'd6, 10'h123);
        intf.wr_en = 1'b1; intf.wr_addr = 4'd7; intf.wr_data = 10'h3FF;
        intf.clr_req = 1'b1;
        tick();
        intf.wr_en = 1'b0; intf.clr_req = 1'b0;
        n = 0;
        while (intf.busy && n < 30) begin
            n++;
            tick();
        end
        expect_eq("clr_len", 32'(n), 32'd10);
        rd(1, 4'd7, 10'h000, "clr_r7");
        rd(0, 4'd6, 10'h000, "clr_r6");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
